decode_issue_ctrl: RTL and testbench

Decode-stage sequencer between fetch and execute in the 5-stage RV32I pipeline. It owns the IF/ID holding slot and classifies the held instruction's immediate format for the immediate generator and operand logic. It inserts load-use bubbles, drains wrong-path fetches after a taken branch/jump, and runs valid/ready handshakes on both sides.

---
 rtl/decode_pkg.sv | 35 +++
 rtl/decode_issue_ctrl_fmt_decode.sv | 27 ++
 rtl/decode_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_decode_issue_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode types: immediate-format codes, RV32I major opcodes and sequencer states.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  // Counter preload for an N-cycle dwell: the state exits after the cycle where the count reads 0.
  function automatic logic [2:0] dwell_load(input int unsigned cycles);
    return 3'(cycles - 1);
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_fmt_decode.sv
// Opcode classifier: immediate format plus which source registers the instruction reads.
// Purely combinational; unknown opcodes read no registers so they can never raise a hazard.
module fmt_decode
  import decode_pkg::*;
(
  input  logic [6:0] i_opcode,
  output imm_fmt_e   o_fmt,
  output logic       o_rs1_used,
  output logic       o_rs2_used
);

  always_comb begin
    o_fmt = FMT_NONE;
    case (i_opcode)
      OP_R:                     o_fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: o_fmt = FMT_I;
      OP_STORE:                 o_fmt = FMT_S;
      OP_BRANCH:                o_fmt = FMT_B;
      OP_LUI, OP_AUIPC:         o_fmt = FMT_U;
      OP_JAL:                   o_fmt = FMT_J;
      default:                  o_fmt = FMT_NONE;
    endcase
    o_rs1_used = o_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    o_rs2_used = o_fmt inside {FMT_R, FMT_S, FMT_B};
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// IF/ID slot sequencer: load-use bubbles, post-redirect fetch drain, valid/ready on both sides.
// DECODE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module decode_issue_ctrl
  import decode_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output imm_fmt_e    id_fmt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [2:0] STALL_LOAD = dwell_load(STALL_CYCLES);
  localparam logic [2:0] FLUSH_LOAD = dwell_load(FLUSH_CYCLES);

  ctrl_state_e r_state;
  logic [2:0]  r_cnt;
  logic        r_slot_vld;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  imm_fmt_e    w_fmt;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_hazard;
  logic        w_run;
  logic        w_fire;
  logic        w_accept;

  fmt_decode u_fmt_decode (
    .i_opcode   (r_inst[6:0]),
    .o_fmt      (w_fmt),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used)
  );

  assign w_hazard = r_slot_vld & ex_mem_read & (ex_rd != 5'd0) &
                    ((w_rs1_used & (r_inst[19:15] == ex_rd)) |
                     (w_rs2_used & (r_inst[24:20] == ex_rd)));

  assign w_run    = (r_state == ST_RUN);
  assign id_valid = w_run & r_slot_vld & ~w_hazard & ~br_taken;
  assign w_fire   = id_valid & id_ready;
  // FLUSH keeps fetch flowing so wrong-path words drain without stalling the front end.
  assign if_ready = (r_state == ST_FLUSH) |
                    (w_run & (~r_slot_vld | w_fire) & ~br_taken);
  assign w_accept = if_valid & if_ready;

  assign id_inst  = r_inst;
  assign id_pc    = r_pc;
  assign id_fmt   = w_fmt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_cnt      <= 3'd0;
      r_slot_vld <= 1'b0;
      r_inst     <= 32'd0;
      r_pc       <= 32'd0;
    end else if (br_taken) begin
      r_state    <= ST_FLUSH;
      r_cnt      <= FLUSH_LOAD;
      r_slot_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            r_state <= ST_STALL;
            r_cnt   <= STALL_LOAD;
          end else if (w_accept) begin
            r_slot_vld <= 1'b1;
            r_inst     <= if_inst;
            r_pc       <= if_pc;
          end else if (w_fire) begin
            r_slot_vld <= 1'b0;
          end
        end
        ST_STALL, ST_FLUSH: begin
          if (r_cnt == 3'd0) r_state <= ST_RUN;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (r_state == ST_STALL && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (r_state == ST_FLUSH && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: two instances (STALL/FLUSH = 1/1 and 3/2) share stimulus,
// each tracked by an abstract cycle model, plus a vector table and directed corner sequences.
module tb_decode_issue_ctrl;

  localparam int S_A = 1, F_A = 1, S_B = 3, F_B = 2;

  logic        clk = 1'b0;
  logic        reset, if_valid, id_ready, ex_mem_read, br_taken;
  logic [31:0] if_inst, if_pc;
  logic [4:0]  ex_rd;

  logic [1:0]  ifr, idv;
  logic [31:0] iinst [2];
  logic [31:0] ipc   [2];
  logic [2:0]  ifmt  [2];
`ifdef DECODE_PERF_CNT_EN
  logic [15:0] scnt [2];
  logic [15:0] fcnt [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_issue_ctrl #(.STALL_CYCLES(S_A), .FLUSH_CYCLES(F_A)) dut_a (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(ifr[0]), .id_valid(idv[0]), .id_ready(id_ready), .id_inst(iinst[0]),
    .id_pc(ipc[0]), .id_fmt(ifmt[0]), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .br_taken(br_taken)
`ifdef DECODE_PERF_CNT_EN
    , .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
`endif
  );

  decode_issue_ctrl #(.STALL_CYCLES(S_B), .FLUSH_CYCLES(F_B)) dut_b (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(ifr[1]), .id_valid(idv[1]), .id_ready(id_ready), .id_inst(iinst[1]),
    .id_pc(ipc[1]), .id_fmt(ifmt[1]), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .br_taken(br_taken)
`ifdef DECODE_PERF_CNT_EN
    , .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Format from the ISA opcode table: 0=R 1=I 2=S 3=B 4=U 5=J 7=none.
  function automatic logic [2:0] ref_fmt(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    if (op == 7'h33) return 3'd0;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 3'd1;
    if (op == 7'h23) return 3'd2;
    if (op == 7'h63) return 3'd3;
    if (op == 7'h37 || op == 7'h17) return 3'd4;
    if (op == 7'h6F) return 3'd5;
    return 3'd7;
  endfunction

  // Reference model: remaining stall / discard cycles counted directly.
  logic        m_en   [2] = '{1'b0, 1'b0};
  logic        m_sv   [2];
  logic [31:0] m_inst [2];
  logic [31:0] m_pc   [2];
  int          m_stl  [2];
  int          m_fls  [2];
  int          m_sc   [2];
  int          m_fc   [2];

  always @(negedge clk) begin : model
    logic [2:0] f;
    logic rd1, rd2, hz, ev, er, fire;
    int sc, fc;
    for (int k = 0; k < 2; k++) begin
      sc  = (k == 0) ? S_A : S_B;
      fc  = (k == 0) ? F_A : F_B;
      f   = ref_fmt(m_inst[k]);
      rd1 = (f <= 3'd3);
      rd2 = (f == 3'd0) || (f == 3'd2) || (f == 3'd3);
      hz  = m_sv[k] && ex_mem_read && (ex_rd != 5'd0) &&
            ((rd1 && m_inst[k][19:15] == ex_rd) || (rd2 && m_inst[k][24:20] == ex_rd));
      if (m_stl[k] > 0) begin
        ev = 1'b0; er = 1'b0;
      end else if (m_fls[k] > 0) begin
        ev = 1'b0; er = 1'b1;
      end else begin
        ev = m_sv[k] && !hz && !br_taken;
        er = (!m_sv[k] || (ev && id_ready)) && !br_taken;
      end
      fire = ev && id_ready;
      if (m_en[k]) begin
        chk($sformatf("model%0d_id_valid", k), idv[k], ev);
        chk($sformatf("model%0d_if_ready", k), ifr[k], er);
        chk($sformatf("model%0d_id_inst", k), iinst[k], m_inst[k]);
        chk($sformatf("model%0d_id_pc", k), ipc[k], m_pc[k]);
        chk($sformatf("model%0d_id_fmt", k), ifmt[k], f);
`ifdef DECODE_PERF_CNT_EN
        chk($sformatf("model%0d_stall_cnt", k), scnt[k], m_sc[k]);
        chk($sformatf("model%0d_flush_cnt", k), fcnt[k], m_fc[k]);
`endif
      end
      if (!reset) begin
        m_en[k] = 1'b1; m_sv[k] = 1'b0; m_inst[k] = '0; m_pc[k] = '0;
        m_stl[k] = 0; m_fls[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        if (m_stl[k] > 0 && m_sc[k] < 65535) m_sc[k]++;
        if (m_fls[k] > 0 && m_fc[k] < 65535) m_fc[k]++;
        if (br_taken) begin
          m_sv[k] = 1'b0; m_stl[k] = 0; m_fls[k] = fc;
        end else if (m_stl[k] > 0) m_stl[k]--;
        else if (m_fls[k] > 0) m_fls[k]--;
        else if (hz) m_stl[k] = sc;
        else if (if_valid && er) begin
          m_sv[k] = 1'b1; m_inst[k] = if_inst; m_pc[k] = if_pc;
        end else if (fire) m_sv[k] = 1'b0;
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [6:0]  op;
    logic [31:0] w;
    case ($urandom_range(0, 9))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h67;  4: op = 7'h23;
      5: op = 7'h63;  6: op = 7'h37;  7: op = 7'h17;  8: op = 7'h6F;  default: op = 7'h7F;
    endcase
    w = $urandom;
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    if_valid = 1'b0; ex_mem_read = 1'b0; br_taken = 1'b0; id_ready = 1'b1;
    repeat (8) adv();
    id_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [2:0]  fmt;
    logic        hz;
  } vec_t;

  localparam logic [31:0] ADD   = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] ADDI  = 32'h00500213;  // addi x4,x0,5
  localparam logic [31:0] ADDX6 = 32'h00128333;  // add x6,x5,x1
  localparam logic [31:0] SW    = 32'h00512023;  // sw x5,0(x2)

  vec_t tv [14];
  int   nb   [2];
  logic done [2];

  initial begin
    tv[0]  = '{32'h002081B3, 5'd5, 3'd0, 1'b0};
    tv[1]  = '{32'h00128333, 5'd5, 3'd0, 1'b1};
    tv[2]  = '{32'h00500213, 5'd0, 3'd1, 1'b0};
    tv[3]  = '{32'h000001B3, 5'd0, 3'd0, 1'b0};
    tv[4]  = '{32'h00128093, 5'd5, 3'd1, 1'b1};
    tv[5]  = '{32'h0002A383, 5'd5, 3'd1, 1'b1};
    tv[6]  = '{32'h00512023, 5'd5, 3'd2, 1'b1};
    tv[7]  = '{32'h00508063, 5'd5, 3'd3, 1'b1};
    tv[8]  = '{32'h000282B7, 5'd5, 3'd4, 1'b0};
    tv[9]  = '{32'h00028297, 5'd5, 3'd4, 1'b0};
    tv[10] = '{32'h000280EF, 5'd5, 3'd5, 1'b0};
    tv[11] = '{32'h00028067, 5'd5, 3'd1, 1'b1};
    tv[12] = '{32'h0002807F, 5'd5, 3'd7, 1'b0};
    tv[13] = '{32'h00500213, 5'd5, 3'd1, 1'b0};

    reset = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; id_ready = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; br_taken = 1'b0;
    repeat (2) adv();
    @(negedge clk);
    chk("reset_id_valid", idv[0], 1'b0);
    chk("reset_if_ready", ifr[0], 1'b1);
    chk("reset_id_fmt", ifmt[0], 3'd7);
    chk("reset_id_inst", iinst[1], 32'd0);
    adv();
    reset = 1'b1;

    // Vector table: load each word, then present a load in EX.
    for (int i = 0; i < 14; i++) begin
      drain();
      if_valid = 1'b1; if_inst = tv[i].inst; if_pc = 32'h1000 + 32'(i * 4);
      adv();
      if_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = tv[i].rd; id_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_fmt", i), ifmt[0], tv[i].fmt);
      chk($sformatf("vec%0d_valid_a", i), idv[0], !tv[i].hz);
      chk($sformatf("vec%0d_valid_b", i), idv[1], !tv[i].hz);
      adv();
    end

    // Pass-through at full rate.
    drain();
    if_valid = 1'b1; if_inst = ADD; if_pc = 32'h100; id_ready = 1'b1;
    adv();
    if_inst = ADDI; if_pc = 32'h104;
    @(negedge clk);
    chk("pass_v0", idv[0], 1'b1);
    chk("pass_inst0", iinst[0], ADD);
    chk("pass_fmt0", ifmt[0], 3'd0);
    chk("pass_rdy0", ifr[0], 1'b1);
    adv();
    if_valid = 1'b0;
    @(negedge clk);
    chk("pass_v1", idv[0], 1'b1);
    chk("pass_inst1", iinst[0], ADDI);
    chk("pass_pc1", ipc[0], 32'h104);
    chk("pass_fmt1", ifmt[0], 3'd1);
    adv();
    @(negedge clk);
    chk("pass_idle", idv[0], 1'b0);

    // Load-use after a fresh reset: detect cycle, then STALL_CYCLES bubbles per instance.
    drain();
    reset = 1'b0;
    adv();
    reset = 1'b1;
`ifdef DECODE_PERF_CNT_EN
    @(negedge clk);
    chk("perf_stall_after_reset", scnt[1], 16'd0);
`endif
    if_valid = 1'b1; if_inst = ADDX6; if_pc = 32'h200;
    adv();
    if_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd5; id_ready = 1'b1;
    @(negedge clk);
    chk("lu_detect_a", idv[0], 1'b0);
    chk("lu_detect_b", idv[1], 1'b0);
    adv();
    ex_mem_read = 1'b0;
    nb = '{0, 0};
    done = '{1'b0, 1'b0};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!done[k]) begin
          if (idv[k]) done[k] = 1'b1;
          else if (!ifr[k]) nb[k]++;
        end
      end
      adv();
    end
    chk("lu_issued_a", done[0], 1'b1);
    chk("lu_issued_b", done[1], 1'b1);
    chk("lu_bubbles_a", nb[0], 32'd1);
    chk("lu_bubbles_b", nb[1], 32'd3);
`ifdef DECODE_PERF_CNT_EN
    chk("perf_stall_a", scnt[0], 16'd1);
    chk("perf_stall_b", scnt[1], 16'd3);
`endif

    // Reset during the second STALL bubble of the 3-cycle instance.
    drain();
    if_valid = 1'b1; if_inst = ADDX6; if_pc = 32'h240;
    adv();
    if_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd5; id_ready = 1'b1;
    adv();
    ex_mem_read = 1'b0;
    adv();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall_bubble2", ifr[1], 1'b0);
    adv();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_stall_valid", idv[1], 1'b0);
    chk("rst_stall_ready", ifr[1], 1'b1);
    chk("rst_stall_inst", iinst[1], 32'd0);
`ifdef DECODE_PERF_CNT_EN
    chk("rst_stall_perf", scnt[1], 16'd0);
`endif
    adv();
    @(negedge clk);
    chk("rst_stall_empty", idv[1], 1'b0);

    // Redirect while a store waits in the slot.
    drain();
    if_valid = 1'b1; if_inst = SW; if_pc = 32'h300;
    adv();
    if_valid = 1'b0; br_taken = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    chk("br_sw_killed", idv[0], 1'b0);
    chk("br_rdy_low", ifr[0], 1'b0);
    adv();
    br_taken = 1'b0; if_valid = 1'b1; if_inst = ADDI; if_pc = 32'h400;
    @(negedge clk);
    chk("flush_rdy", ifr[0], 1'b1);
    chk("flush_valid", idv[0], 1'b0);
    adv();
    if_inst = ADD; if_pc = 32'h404;
    @(negedge clk);
    chk("flush_dropped", idv[0], 1'b0);
    adv();
    if_valid = 1'b0;
    @(negedge clk);
    chk("after_flush_valid", idv[0], 1'b1);
    chk("after_flush_inst", iinst[0], ADD);
    chk("after_flush_pc", ipc[0], 32'h404);
    adv();

    // Backpressure for four cycles, then fire with a new word arriving.
    drain();
    if_valid = 1'b1; if_inst = ADDI; if_pc = 32'h500;
    adv();
    for (int c = 0; c < 4; c++) begin
      if_inst = rand_inst(); if_pc = 32'h600 + 32'(c);
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), idv[0], 1'b1);
      chk($sformatf("bp%0d_inst", c), iinst[0], ADDI);
      chk($sformatf("bp%0d_pc", c), ipc[0], 32'h500);
      chk($sformatf("bp%0d_rdy", c), ifr[0], 1'b0);
      adv();
    end
    id_ready = 1'b1; if_inst = ADD; if_pc = 32'h504;
    @(negedge clk);
    chk("bp_fire_valid", idv[0], 1'b1);
    chk("bp_fire_rdy", ifr[0], 1'b1);
    adv();
    if_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_inst", iinst[0], ADD);
    adv();

    // Random traffic checked by the model.
    drain();
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 99) != 0);
      if_valid    = ($urandom_range(0, 3) != 0);
      if_inst     = rand_inst();
      if_pc       = $urandom;
      id_ready    = ($urandom_range(0, 3) != 0);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      br_taken    = !br_taken && ($urandom_range(0, 15) == 0);
      adv();
    end
    reset = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
